cpu_sequencer: RTL and testbench

//  Multi-cycle control unit for the CPU core. Fetches a 16-bit word over an imem req/ack port into
//  an instruction register ir_o, which feeds inst_decoder. Uses the decoded fields to sequence an

---
 rtl/nandgame_pkg.sv | 32 +++
 rtl/pc_unit.sv | 32 +++
 rtl/cpu_sequencer.sv | 142 ++++++++++++++
 tb/tb_cpu_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nandgame_pkg.sv
// Shared types for the multi-cycle CPU sequencer.
// Instruction word, decoder field bundles, FSM states.
package nandgame_pkg;

  typedef logic [15:0] inst_word_t;

  typedef struct packed {
    logic a;
    logic d;
    logic m;
  } dst_flag_t;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } jmp_flag_t;

  typedef enum logic [2:0] {
    HALT,
    FETCH,
    DECODE,
    MEMRD,
    MEMWR,
    COMMIT
  } seq_state_t;

  localparam int DST_A = 2;
  localparam int DST_D = 1;
  localparam int DST_M = 0;

endpackage

// File: rtl/pc_unit.sv
// Program counter: increment or load, wraps at 2^AW.
// Holds its value unless en is high.
module pc_unit #(
  parameter int            AW       = 16,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          load,
  input  logic [AW-1:0] d,
  output logic [AW-1:0] pc
);

  logic [AW-1:0] pc_q;
  logic [AW-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (en) begin
      pc_d = load ? d : pc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control: fetch, optional *A read/write, commit.
// Run/step/halt debug control and retired-instruction counter.
module cpu_sequencer
  import nandgame_pkg::*;
#(
  parameter int            AW       = 16,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run_i,
  input  logic          step_i,
  output logic          halted_o,
  output logic          imem_req_o,
  output logic [AW-1:0] imem_addr_o,
  input  logic          imem_ack_i,
  input  logic [15:0]   imem_rdata_i,
  output logic [15:0]   ir_o,
  input  logic          dec_ci_i,
  input  logic          dec_sm_i,
  input  logic [2:0]    dec_dst_i,
  input  logic          jump_i,
  input  logic [AW-1:0] a_i,
  input  logic [15:0]   alu_i,
  output logic          dmem_req_o,
  output logic          dmem_we_o,
  output logic [AW-1:0] dmem_addr_o,
  output logic [15:0]   dmem_wdata_o,
  input  logic          dmem_ack_i,
  input  logic [15:0]   dmem_rdata_i,
  output logic [15:0]   mem_q_o,
  output logic          a_we_o,
  output logic          d_we_o,
  output logic [AW-1:0] pc_o,
  output logic [31:0]   retired_o
);

  seq_state_t state_q, state_d;
  logic       step_q, step_d;
  inst_word_t ir_q, ir_d;
  logic [15:0] mem_q_q, mem_q_d;
  logic [31:0] retired_q, retired_d;
  logic       commit;

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    ir_d      = ir_q;
    mem_q_d   = mem_q_q;
    retired_d = retired_q;
    unique case (state_q)
      HALT: begin
        if (run_i) begin
          state_d = FETCH;
          step_d  = 1'b0;
        end else if (step_i) begin
          state_d = FETCH;
          step_d  = 1'b1;
        end
      end
      FETCH: begin
        if (imem_ack_i) begin
          ir_d    = imem_rdata_i;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (dec_ci_i && dec_sm_i)
          state_d = MEMRD;
        else if (dec_ci_i && dec_dst_i[DST_M])
          state_d = MEMWR;
        else
          state_d = COMMIT;
      end
      MEMRD: begin
        if (dmem_ack_i) begin
          mem_q_d = dmem_rdata_i;
          state_d = dec_dst_i[DST_M] ? MEMWR : COMMIT;
        end
      end
      MEMWR: begin
        if (dmem_ack_i) state_d = COMMIT;
      end
      COMMIT: begin
        retired_d = retired_q + 32'd1;
        if (run_i && !step_q) begin
          state_d = FETCH;
        end else begin
          state_d = HALT;
          step_d  = 1'b0;
        end
      end
      default: state_d = HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HALT;
      step_q    <= 1'b0;
      ir_q      <= '0;
      mem_q_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      ir_q      <= ir_d;
      mem_q_q   <= mem_q_d;
      retired_q <= retired_d;
    end
  end

  assign commit = (state_q == COMMIT);

  pc_unit #(
    .AW       (AW),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (commit),
    .load  (jump_i),
    .d     (a_i),
    .pc    (pc_o)
  );

  // Strobes come straight from state so reset kills them immediately
  assign halted_o     = (state_q == HALT);
  assign imem_req_o   = (state_q == FETCH);
  assign imem_addr_o  = pc_o;
  assign dmem_req_o   = (state_q == MEMRD) || (state_q == MEMWR);
  assign dmem_we_o    = (state_q == MEMWR);
  assign dmem_addr_o  = a_i;
  assign dmem_wdata_o = alu_i;
  assign ir_o         = ir_q;
  assign mem_q_o      = mem_q_q;
  assign retired_o    = retired_q;
  // Constant-load words always target A
  assign a_we_o = commit && (dec_dst_i[DST_A] || !dec_ci_i);
  assign d_we_o = commit && dec_dst_i[DST_D];

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: vector table plus
// hand sequences for step, run, and mid-transfer reset.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run_i = 1'b0;
  logic        step_i = 1'b0;
  logic        halted_o;
  logic        imem_req_o;
  logic [15:0] imem_addr_o;
  logic        imem_ack_i;
  logic [15:0] imem_rdata_i = '0;
  logic [15:0] ir_o;
  logic        dec_ci_i = 1'b0;
  logic        dec_sm_i = 1'b0;
  logic [2:0]  dec_dst_i = '0;
  logic        jump_i = 1'b0;
  logic [15:0] a_i = '0;
  logic [15:0] alu_i = '0;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [15:0] dmem_addr_o;
  logic [15:0] dmem_wdata_o;
  logic        dmem_ack_i;
  logic [15:0] dmem_rdata_i = '0;
  logic [15:0] mem_q_o;
  logic        a_we_o;
  logic        d_we_o;
  logic [15:0] pc_o;
  logic [31:0] retired_o;

  int n_vec = 0;
  int n_bad = 0;
  int idly = 0;
  int ddly = 0;
  int icnt = 0;
  int dcnt = 0;

  always #5 clk = ~clk;

  cpu_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run_i        (run_i),
    .step_i       (step_i),
    .halted_o     (halted_o),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ack_i   (imem_ack_i),
    .imem_rdata_i (imem_rdata_i),
    .ir_o         (ir_o),
    .dec_ci_i     (dec_ci_i),
    .dec_sm_i     (dec_sm_i),
    .dec_dst_i    (dec_dst_i),
    .jump_i       (jump_i),
    .a_i          (a_i),
    .alu_i        (alu_i),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_ack_i   (dmem_ack_i),
    .dmem_rdata_i (dmem_rdata_i),
    .mem_q_o      (mem_q_o),
    .a_we_o       (a_we_o),
    .d_we_o       (d_we_o),
    .pc_o         (pc_o),
    .retired_o    (retired_o)
  );

  // Memory responders with programmable wait states
  always @(posedge clk) begin
    icnt <= (imem_req_o && !imem_ack_i) ? icnt + 1 : 0;
    dcnt <= (dmem_req_o && !dmem_ack_i) ? dcnt + 1 : 0;
  end
  assign imem_ack_i = imem_req_o && (icnt == idly);
  assign dmem_ack_i = dmem_req_o && (dcnt == ddly);

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] word;
    logic        ci;
    logic        sm;
    logic [2:0]  dst;
    logic        jmp;
    logic [15:0] a;
    logic [15:0] alu;
    logic [15:0] rdat;
    int          dly;
    int          cyc;
    logic [15:0] pc;
    int          awe;
    int          dwe;
    int          rd;
    int          wr;
  } vec_t;

  task automatic exec(input vec_t v, input int idx);
    int cyc, rd, wr, awe, dwe, aerr;
    logic [31:0] r0;
    string tag;
    tag = $sformatf("v%0d", idx);
    cyc = 0; rd = 0; wr = 0; awe = 0; dwe = 0; aerr = 0;
    @(negedge clk);
    imem_rdata_i = v.word;
    dec_ci_i = v.ci;
    dec_sm_i = v.sm;
    dec_dst_i = v.dst;
    jump_i = v.jmp;
    a_i = v.a;
    alu_i = v.alu;
    dmem_rdata_i = v.rdat;
    ddly = v.dly;
    r0 = retired_o;
    step_i = 1'b1;
    @(posedge clk);
    #1 step_i = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (halted_o) break;
      cyc++;
      if (a_we_o) awe++;
      if (d_we_o) dwe++;
      if (dmem_req_o && dmem_ack_i) begin
        if (dmem_addr_o !== v.a) aerr++;
        if (dmem_we_o) begin
          wr++;
          if (dmem_wdata_o !== v.alu) aerr++;
        end else begin
          rd++;
        end
      end
    end
    chk({tag, " cycles"}, cyc, v.cyc);
    chk({tag, " pc"}, {16'h0, pc_o}, {16'h0, v.pc});
    chk({tag, " retired"}, retired_o, r0 + 32'd1);
    chk({tag, " a_we"}, awe, v.awe);
    chk({tag, " d_we"}, dwe, v.dwe);
    chk({tag, " reads"}, rd, v.rd);
    chk({tag, " writes"}, wr, v.wr);
    chk({tag, " ir"}, {16'h0, ir_o}, {16'h0, v.word});
    chk({tag, " addr/wdata"}, aerr, 0);
    if (v.rd != 0) chk({tag, " mem_q"}, {16'h0, mem_q_o}, {16'h0, v.rdat});
  endtask

  vec_t vt[9];

  initial begin
    int bad, cyc, r0;
    vt[0] = '{16'h0005, 0, 0, 3'b100, 0, 16'h0000, 16'h0000, 16'h0000, 0, 3, 16'h0002, 1, 0, 0, 0};
    vt[1] = '{16'h8010, 1, 0, 3'b010, 0, 16'h0000, 16'h0042, 16'h0000, 0, 3, 16'h0003, 0, 1, 0, 0};
    vt[2] = '{16'h9010, 1, 1, 3'b010, 0, 16'h0010, 16'h0000, 16'hBEEF, 0, 4, 16'h0004, 0, 1, 1, 0};
    vt[3] = '{16'h8008, 1, 0, 3'b001, 0, 16'h0020, 16'h5555, 16'h0000, 1, 5, 16'h0005, 0, 0, 0, 1};
    vt[4] = '{16'h9018, 1, 1, 3'b011, 0, 16'h0010, 16'h1234, 16'hCAFE, 2, 9, 16'h0006, 0, 1, 1, 1};
    vt[5] = '{16'h8007, 1, 0, 3'b000, 1, 16'h1234, 16'h0000, 16'h0000, 0, 3, 16'h1234, 0, 0, 0, 0};
    vt[6] = '{16'h8007, 1, 0, 3'b000, 1, 16'hFFFF, 16'h0000, 16'h0000, 0, 3, 16'hFFFF, 0, 0, 0, 0};
    vt[7] = '{16'h8007, 1, 0, 3'b000, 0, 16'hFFFF, 16'h0000, 16'h0000, 0, 3, 16'h0000, 0, 0, 0, 0};
    vt[8] = '{16'h8028, 1, 0, 3'b101, 0, 16'h0040, 16'h0077, 16'h0000, 0, 4, 16'h0001, 1, 0, 0, 1};

    repeat (3) @(negedge clk);
    chk("rst halted", {31'h0, halted_o}, 1);
    chk("rst pc", {16'h0, pc_o}, 0);
    chk("rst ir", {16'h0, ir_o}, 0);
    chk("rst mem_q", {16'h0, mem_q_o}, 0);
    chk("rst retired", retired_o, 0);
    chk("rst reqs", {30'h0, imem_req_o, dmem_req_o}, 0);
    rst_n = 1'b1;

    // Constant load under run, then run drops during COMMIT
    @(negedge clk);
    imem_rdata_i = 16'h0005;
    dec_ci_i = 1'b0;
    dec_dst_i = 3'b100;
    run_i = 1'b1;
    @(negedge clk);
    chk("t1 fetch req", {31'h0, imem_req_o}, 1);
    chk("t1 fetch addr", {16'h0, imem_addr_o}, 0);
    @(negedge clk);
    @(negedge clk);
    chk("t1 commit a_we", {31'h0, a_we_o}, 1);
    chk("t1 commit d_we", {31'h0, d_we_o}, 0);
    run_i = 1'b0;
    @(negedge clk);
    chk("t1 halted", {31'h0, halted_o}, 1);
    chk("t1 pc", {16'h0, pc_o}, 1);
    chk("t1 retired", retired_o, 1);

    for (int i = 0; i < 9; i++) exec(vt[i], i);

    // Step during FETCH must not start a second instruction
    dec_ci_i = 1'b1; dec_sm_i = 1'b0; dec_dst_i = 3'b000; jump_i = 1'b0;
    idly = 2;
    r0 = retired_o;
    @(negedge clk);
    step_i = 1'b1;
    @(posedge clk);
    #1 step_i = 1'b0;
    @(negedge clk);
    step_i = 1'b1;
    @(negedge clk);
    step_i = 1'b0;
    cyc = 0;
    while (!halted_o && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    chk("step halted", {31'h0, halted_o}, 1);
    repeat (4) @(negedge clk);
    chk("step one retire", retired_o, r0 + 1);
    chk("step stays halted", {31'h0, halted_o}, 1);
    idly = 0;

    // run and step together: continuous execution
    r0 = retired_o;
    run_i = 1'b1;
    step_i = 1'b1;
    @(negedge clk);
    step_i = 1'b0;
    repeat (12) @(negedge clk);
    chk("run+step running", {31'h0, halted_o}, 0);
    chk("run+step multi", {31'h0, (retired_o - r0) >= 3}, 1);
    run_i = 1'b0;
    cyc = 0;
    while (!halted_o && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    chk("run drop halts", {31'h0, halted_o}, 1);

    // Reset in the middle of a write transfer
    dec_ci_i = 1'b1; dec_sm_i = 1'b0; dec_dst_i = 3'b011;
    a_i = 16'h0030; alu_i = 16'h00AA;
    ddly = 6;
    @(negedge clk);
    step_i = 1'b1;
    @(posedge clk);
    #1 step_i = 1'b0;
    cyc = 0;
    while (!(dmem_req_o && dmem_we_o) && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    chk("memwr reached", {30'h0, dmem_req_o, dmem_we_o}, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst dmem_req", {31'h0, dmem_req_o}, 0);
    chk("rst pc mid", {16'h0, pc_o}, 0);
    chk("rst halted mid", {31'h0, halted_o}, 1);
    chk("rst retired mid", retired_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ddly = 0;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (a_we_o || d_we_o || dmem_req_o || imem_req_o) bad++;
    end
    chk("post rst strobes", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
